// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for the shared 12-bit address / 16-bit data bus.
// Define ARB_KBD_PROTECT_EN to block m1 accesses to the keyboard ports.
module mem_bus_arbiter #(
    parameter int unsigned MAX_BURST = 8,
    parameter logic [11:0] PARK_ADDR = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic [11:0] m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic        m0_we,
    output logic        m0_gnt,
    input  logic        m1_req,
    input  logic [11:0] m1_addr,
    input  logic [15:0] m1_wdata,
    input  logic        m1_we,
    output logic        m1_gnt,
    output logic        m1_err,
    output logic [15:0] rdata,
    output logic [11:0] bus_addr,
    output logic [15:0] bus_dout,
    output logic        bus_we,
    input  logic [15:0] bus_din
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWN0,
        S_OWN1
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(MAX_BURST - 1);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_last;
    logic       r_m0_gnt;
    logic       r_m1_gnt;

    logic       w_lim;
    logic       w_m0_act;
    logic       w_m1_act;
    logic       w_m1_blk;

    assign w_lim = (r_cnt == LP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= 8'd0;
            r_last   <= 1'b1;
            r_m0_gnt <= 1'b0;
            r_m1_gnt <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= 8'd0;
                    if (m0_req && (!m1_req || r_last)) begin
                        r_state  <= S_OWN0;
                        r_last   <= 1'b0;
                        r_m0_gnt <= 1'b1;
                    end else if (m1_req) begin
                        r_state  <= S_OWN1;
                        r_last   <= 1'b1;
                        r_m1_gnt <= 1'b1;
                    end
                end
                S_OWN0: begin
                    if (!m0_req || (m1_req && w_lim)) begin
                        r_cnt    <= 8'd0;
                        r_m0_gnt <= 1'b0;
                        if (m1_req) begin
                            r_state  <= S_OWN1;
                            r_last   <= 1'b1;
                            r_m1_gnt <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (!w_lim) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_OWN1: begin
                    if (!m1_req || (m0_req && w_lim)) begin
                        r_cnt    <= 8'd0;
                        r_m1_gnt <= 1'b0;
                        if (m0_req) begin
                            r_state  <= S_OWN0;
                            r_last   <= 1'b0;
                            r_m0_gnt <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (!w_lim) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_cnt    <= 8'd0;
                    r_m0_gnt <= 1'b0;
                    r_m1_gnt <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_KBD_PROTECT_EN
    // m1 must not consume keyboard acknowledges
    assign w_m1_blk = r_m1_gnt && m1_req &&
                      ((m1_addr == 12'h900) || (m1_addr == 12'h901));
`else
    assign w_m1_blk = 1'b0;
`endif

    assign w_m0_act = r_m0_gnt && m0_req;
    assign w_m1_act = r_m1_gnt && m1_req && !w_m1_blk;

    always_comb begin
        bus_addr = PARK_ADDR;
        bus_dout = 16'h0000;
        bus_we   = 1'b0;
        if (w_m0_act) begin
            bus_addr = m0_addr;
            bus_dout = m0_wdata;
            bus_we   = m0_we;
        end else if (w_m1_act) begin
            bus_addr = m1_addr;
            bus_dout = m1_wdata;
            bus_we   = m1_we;
        end
    end

    assign rdata  = w_m1_blk ? 16'hF345 : bus_din;
    assign m1_err = w_m1_blk;
    assign m0_gnt = r_m0_gnt;
    assign m1_gnt = r_m1_gnt;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed vector bench for mem_bus_arbiter (default MAX_BURST=8, PARK_ADDR=0).
// Keyboard-protect expectations follow ARB_KBD_PROTECT_EN when it is defined.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0;
    logic [11:0] m0_addr = '0;
    logic [15:0] m0_wdata = '0;
    logic        m0_we = 1'b0;
    logic        m0_gnt;
    logic        m1_req = 1'b0;
    logic [11:0] m1_addr = '0;
    logic [15:0] m1_wdata = '0;
    logic        m1_we = 1'b0;
    logic        m1_gnt;
    logic        m1_err;
    logic [15:0] rdata;
    logic [11:0] bus_addr;
    logic [15:0] bus_dout;
    logic        bus_we;
    logic [15:0] bus_din = '0;

`ifdef ARB_KBD_PROTECT_EN
    localparam bit KP = 1'b1;
`else
    localparam bit KP = 1'b0;
`endif

    mem_bus_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m0_req  (m0_req),
        .m0_addr (m0_addr),
        .m0_wdata(m0_wdata),
        .m0_we   (m0_we),
        .m0_gnt  (m0_gnt),
        .m1_req  (m1_req),
        .m1_addr (m1_addr),
        .m1_wdata(m1_wdata),
        .m1_we   (m1_we),
        .m1_gnt  (m1_gnt),
        .m1_err  (m1_err),
        .rdata   (rdata),
        .bus_addr(bus_addr),
        .bus_dout(bus_dout),
        .bus_we  (bus_we),
        .bus_din (bus_din)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0;
        logic [11:0] a0;
        logic        w0;
        logic [15:0] d0;
        logic        r1;
        logic [11:0] a1;
        logic        w1;
        logic [15:0] d1;
        logic [15:0] din;
        logic        g0;
        logic        g1;
        logic [11:0] addr;
        logic        we;
        logic [15:0] dout;
        logic [15:0] rd;
        logic        err;
    } vec_t;

    vec_t tv[20];
    int   errs = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r0, input logic [11:0] a0,
                         input logic w0, input logic [15:0] d0,
                         input logic r1, input logic [11:0] a1,
                         input logic w1, input logic [15:0] d1);
        m0_req = r0; m0_addr = a0; m0_we = w0; m0_wdata = d0;
        m1_req = r1; m1_addr = a1; m1_we = w1; m1_wdata = d1;
    endtask

    initial begin
        tv[0]  = '{1, 12'h010, 1, 16'h1234, 0, 12'h000, 0, 16'h0000, 16'h0AAA,
                   0, 0, 12'h000, 0, 16'h0000, 16'h0AAA, 0};
        tv[1]  = '{1, 12'h010, 1, 16'h1234, 0, 12'h000, 0, 16'h0000, 16'h0BBB,
                   1, 0, 12'h010, 1, 16'h1234, 16'h0BBB, 0};
        tv[2]  = '{0, 12'h010, 1, 16'h1234, 1, 12'h123, 1, 16'hBEEF, 16'h0CCC,
                   1, 0, 12'h000, 0, 16'h0000, 16'h0CCC, 0};
        tv[3]  = '{1, 12'h201, 0, 16'h0000, 1, 12'h123, 1, 16'hBEEF, 16'h0DDD,
                   0, 1, 12'h123, 1, 16'hBEEF, 16'h0DDD, 0};
        tv[4]  = '{1, 12'h201, 0, 16'h0000, 0, 12'h123, 1, 16'hBEEF, 16'h0EEE,
                   0, 1, 12'h000, 0, 16'h0000, 16'h0EEE, 0};
        tv[5]  = '{1, 12'h201, 0, 16'h0000, 0, 12'h000, 0, 16'h0000, 16'h1357,
                   1, 0, 12'h201, 0, 16'h0000, 16'h1357, 0};
        tv[6]  = '{0, 12'h000, 0, 16'h0000, 0, 12'h000, 0, 16'h0000, 16'h2468,
                   1, 0, 12'h000, 0, 16'h0000, 16'h2468, 0};
        for (int i = 7; i < 12; i++)
            tv[i] = '{0, 12'h000, 0, 16'h0000, 0, 12'h000, 0, 16'h0000,
                      16'(i * 16'h1111 - 16'h6666),
                      0, 0, 12'h000, 0, 16'h0000,
                      16'(i * 16'h1111 - 16'h6666), 0};
        tv[12] = '{1, 12'h201, 0, 16'h0000, 0, 12'h000, 0, 16'h0000, 16'h6666,
                   0, 0, 12'h000, 0, 16'h0000, 16'h6666, 0};
        tv[13] = '{1, 12'h201, 0, 16'h0000, 0, 12'h000, 0, 16'h0000, 16'h7777,
                   1, 0, 12'h201, 0, 16'h0000, 16'h7777, 0};
        tv[14] = '{0, 12'h000, 0, 16'h0000, 1, 12'h900, 0, 16'h0000, 16'h00C3,
                   1, 0, 12'h000, 0, 16'h0000, 16'h00C3, 0};
        tv[15] = '{0, 12'h000, 0, 16'h0000, 1, 12'h900, 0, 16'h0000, 16'h00C4,
                   0, 1, KP ? 12'h000 : 12'h900, 0, 16'h0000,
                   KP ? 16'hF345 : 16'h00C4, KP};
        tv[16] = '{0, 12'h000, 0, 16'h0000, 1, 12'h901, 1, 16'h0042, 16'h00C5,
                   0, 1, KP ? 12'h000 : 12'h901, !KP,
                   KP ? 16'h0000 : 16'h0042,
                   KP ? 16'hF345 : 16'h00C5, KP};
        tv[17] = '{0, 12'h000, 0, 16'h0000, 1, 12'h100, 1, 16'h0077, 16'h00C6,
                   0, 1, 12'h100, 1, 16'h0077, 16'h00C6, 0};
        tv[18] = '{0, 12'h000, 0, 16'h0000, 0, 12'h100, 1, 16'h0077, 16'h00C7,
                   0, 1, 12'h000, 0, 16'h0000, 16'h00C7, 0};
        tv[19] = '{0, 12'h000, 0, 16'h0000, 0, 12'h000, 0, 16'h0000, 16'h00C8,
                   0, 0, 12'h000, 0, 16'h0000, 16'h00C8, 0};

        tick();
        tick();
        chk("rst_g0", 16'(m0_gnt), 16'h0);
        chk("rst_g1", 16'(m1_gnt), 16'h0);
        chk("rst_err", 16'(m1_err), 16'h0);
        chk("rst_addr", 16'(bus_addr), 16'h000);
        chk("rst_we", 16'(bus_we), 16'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            tick();
            drive(tv[i].r0, tv[i].a0, tv[i].w0, tv[i].d0,
                  tv[i].r1, tv[i].a1, tv[i].w1, tv[i].d1);
            bus_din = tv[i].din;
            #1;
            chk($sformatf("v%0d_g0", i), 16'(m0_gnt), 16'(tv[i].g0));
            chk($sformatf("v%0d_g1", i), 16'(m1_gnt), 16'(tv[i].g1));
            chk($sformatf("v%0d_addr", i), 16'(bus_addr), 16'(tv[i].addr));
            chk($sformatf("v%0d_we", i), 16'(bus_we), 16'(tv[i].we));
            chk($sformatf("v%0d_dout", i), bus_dout, tv[i].dout);
            chk($sformatf("v%0d_rdata", i), rdata, tv[i].rd);
            chk($sformatf("v%0d_err", i), 16'(m1_err), 16'(tv[i].err));
        end

        // both masters contend: 8-cycle windows, m0 first, no gap
        tick();
        drive(1, 12'h0A0, 0, 16'h0000, 1, 12'h0B0, 0, 16'h0000);
        #1;
        chk("rr_c0_g0", 16'(m0_gnt), 16'h0);
        chk("rr_c0_g1", 16'(m1_gnt), 16'h0);
        for (int i = 1; i <= 40; i++) begin
            logic own1;
            tick();
            own1 = (((i - 1) / 8) % 2) == 1;
            chk($sformatf("rr%0d_g0", i), 16'(m0_gnt), 16'(!own1));
            chk($sformatf("rr%0d_g1", i), 16'(m1_gnt), 16'(own1));
            chk($sformatf("rr%0d_addr", i), 16'(bus_addr),
                own1 ? 16'h0B0 : 16'h0A0);
        end
        tick();
        chk("rr41_g1", 16'(m1_gnt), 16'h1);
        drive(0, 12'h000, 0, 16'h0000, 0, 12'h000, 0, 16'h0000);
        tick();
        tick();

        // async reset mid-burst
        drive(1, 12'h033, 1, 16'h9999, 0, 12'h000, 0, 16'h0000);
        tick();
        chk("mb_c1_g0", 16'(m0_gnt), 16'h1);
        tick();
        tick();
        chk("mb_c3_g0", 16'(m0_gnt), 16'h1);
        chk("mb_c3_we", 16'(bus_we), 16'h1);
        rst_n = 1'b0;
        #1;
        chk("mb_rst_g0", 16'(m0_gnt), 16'h0);
        chk("mb_rst_addr", 16'(bus_addr), 16'h000);
        chk("mb_rst_we", 16'(bus_we), 16'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mb_rel_g0", 16'(m0_gnt), 16'h0);
        tick();
        chk("mb_regnt_g0", 16'(m0_gnt), 16'h1);
        chk("mb_regnt_addr", 16'(bus_addr), 16'h033);
        chk("mb_regnt_dout", bus_dout, 16'h9999);

        // unopposed burst holds past MAX_BURST, then saturated handover
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("hold%0d_g0", i), 16'(m0_gnt), 16'h1);
            chk($sformatf("hold%0d_g1", i), 16'(m1_gnt), 16'h0);
        end
        m1_req = 1'b1;
        m1_addr = 12'h0C0;
        #1;
        chk("sat_g0", 16'(m0_gnt), 16'h1);
        tick();
        chk("sat_h_g0", 16'(m0_gnt), 16'h0);
        chk("sat_h_g1", 16'(m1_gnt), 16'h1);
        chk("sat_h_addr", 16'(bus_addr), 16'h0C0);
        drive(0, 12'h000, 0, 16'h0000, 0, 12'h000, 0, 16'h0000);
        tick();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 12-bit address / 16-bit data memory-mapped bus between two masters: m0 (the bird CPU) and m1 (a secondary master such as a sprite/coordinate updater).
- The bus covers RAM 0x000–0x1FF, XDATA 0x200, YDATA 0x201, KEYBOARD 0x900/0x901 and VGA 0xB00.
- Registered round-robin grant, per-grant burst limit, bus parking when idle.
- Sits between the masters and the top-level address decoder; the decoder sees one master only.

Parameters:
- MAX_BURST, 8, max consecutive granted cycles before forced handover when the other master is requesting; legal range 1..255.
- PARK_ADDR, 12'h000, address driven when no transfer is active; must be a RAM address, never KEYBOARD.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 requests the bus
- m0_addr  in  12  master 0 address
- m0_wdata  in  16  master 0 write data
- m0_we  in  1  master 0 write enable
- m0_gnt  out  1  master 0 owns the bus this cycle
- m1_req  in  1  master 1 requests the bus
- m1_addr  in  12  master 1 address
- m1_wdata  in  16  master 1 write data
- m1_we  in  1  master 1 write enable
- m1_gnt  out  1  master 1 owns the bus this cycle
- m1_err  out  1  one-cycle pulse: m1 access was blocked (see Optional Feature)
- rdata  out  16  read data returned to both masters; equals bus_din
- bus_addr  out  12  address to the decoder
- bus_dout  out  16  write data to the decoder
- bus_we  out  1  write strobe to the decoder
- bus_din  in  16  read data from the decoder

Behaviour:
- Reset (async, rst_n=0): state IDLE, m0_gnt=0, m1_gnt=0, m1_err=0, burst counter=0, last-owner=1, so m0 wins the first tie.
- States:
  - IDLE: no grant.
  - OWN0: m0_gnt=1.
  - OWN1: m1_gnt=1.
- Grants are registered. A request sampled at posedge N gives gnt high from N+1. A master transfers in every cycle where gnt=1 and req=1.
- Bus mux (combinational):
  - When owner gnt&req: bus_addr/bus_dout/bus_we = owner's signals.
  - Otherwise: bus_addr=PARK_ADDR, bus_dout=0, bus_we=0.
- rdata = bus_din always; it is valid in the same cycle as the address, since the memory read is combinational.
- IDLE transitions:
  - Only m0_req → OWN0.
  - Only m1_req → OWN1.
  - Both → the master that is not last-owner.
  - Neither → IDLE.
- OWNx transitions, evaluated at each posedge:
  - Owner req=0 → release. Go directly to the other owner if its req=1, else IDLE. No dead cycle.
  - Owner req=1, other req=1, counter=MAX_BURST-1 → forced handover to the other master.
  - Otherwise stay; counter increments, saturating at MAX_BURST-1.
- Counter resets to 0 on every grant change, including into IDLE. On entering OWNx, last-owner ← x.
- A burst is never preempted while the other master is not requesting; an unopposed master holds the bus indefinitely.
- m0_gnt and m1_gnt are never both 1. bus_we never asserts without a gnt.
- The owner dropping req in the same cycle its burst limit expires counts as a release; the result is the same grant outcome as a handover.
- rst_n asserted mid-burst: grants drop immediately (async) and the bus parks. Any in-flight write is abandoned; the master must retry.

Optional Feature:
- Macro: ARB_KBD_PROTECT_EN.
- With the macro defined:
  - Any m1 granted cycle with m1_addr in {0x900, 0x901} is suppressed: bus_addr=PARK_ADDR, bus_we=0, rdata driven 16'hF345.
  - m1_err pulses high for that cycle.
  - Purpose: prevents m1 from consuming keyboard acknowledges.
- Without the macro: m1 KEYBOARD accesses pass through unchanged and m1_err is tied 0.
- m0 is never filtered in either configuration.

Test Plan:
- Reset, then m0_req=1 only, m0_addr=0x010, m0_we=1, m0_wdata=0x1234 → m0_gnt rises on the next edge; bus_addr=0x010, bus_we=1 while granted; m1_gnt stays 0.
- m0_req and m1_req both held high, MAX_BURST=8 → grants alternate in 8-cycle windows starting with m0; never both high; no idle gap at the handover.
- m1 owns the bus and drops req while m0_req=1 → m0_gnt=1 on the very next cycle; bus_we=0 in the cycle m1 had gnt but no req.
- Both masters idle for 5 cycles → bus_addr=0x000, bus_we=0 throughout; a read by m0 of 0x201 afterwards returns bus_din on rdata in the same cycle.
- ARB_KBD_PROTECT_EN defined, m1 reads 0x900 → bus_addr=0x000, rdata=0xF345, m1_err one-cycle pulse. Same stimulus without the macro → bus_addr=0x900, m1_err=0.
- rst_n pulled low for 1 cycle during an m0 burst at cycle 3 → m0_gnt=0 immediately; after release, m0 is re-granted one cycle after its req is sampled.
